// File: rtl/approx_mult_pkg.sv
// Shared types and widths for the approximate-multiplier error monitor.
// Optional max-ED tracking in the monitor is enabled by defining ERR_MAX_TRACK_EN.
package approx_mult_pkg;

   localparam int unsigned OPW   = 8;
   localparam int unsigned PRODW = 16;
   localparam int unsigned EDW   = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } mon_state_e;

   // Unsigned |x - y|; the approximate product may sit on either side of the exact one.
   function automatic logic [EDW-1:0] abs_diff(input logic [PRODW-1:0] x,
                                                input logic [PRODW-1:0] y);
      return (x >= y) ? EDW'(x - y) : EDW'(y - x);
   endfunction

endpackage

// File: rtl/err_dist_calc.sv
// Two-stage error-distance pipeline: stage 1 registers the exact A*B and R,
// stage 2 registers ED = |A*B - R|.
module err_dist_calc
   import approx_mult_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [OPW-1:0]   in_a,
   input  logic [OPW-1:0]   in_b,
   input  logic [PRODW-1:0] in_r,
   output logic             s1_valid,
   output logic             ed_valid,
   output logic [EDW-1:0]   ed
);

   logic [PRODW-1:0] prod_q;
   logic [PRODW-1:0] r_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         ed_valid <= 1'b0;
      end else begin
         s1_valid <= in_valid;
         ed_valid <= s1_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (in_valid) begin
         prod_q <= PRODW'(in_a) * PRODW'(in_b);
         r_q    <= in_r;
      end
      if (s1_valid) begin
         ed <= abs_diff(prod_q, r_q);
      end
   end

endmodule

// File: rtl/approx_mult_err_monitor.sv
// Windowed error statistics (sum/count/max of ED) for an 8x8 approximate multiplier.
// Define ERR_MAX_TRACK_EN to build the max_ed tracker; otherwise max_ed is tied to 0.
module approx_mult_err_monitor
   import approx_mult_pkg::*;
#(
   parameter int unsigned SAMPLE_CNT_W = 16,
   parameter int unsigned ACC_W        = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [SAMPLE_CNT_W-1:0] num_samples,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [OPW-1:0]          in_a,
   input  logic [OPW-1:0]          in_b,
   input  logic [PRODW-1:0]        in_r,
   output logic                    busy,
   output logic                    done,
   output logic [ACC_W-1:0]        sum_ed,
   output logic [SAMPLE_CNT_W-1:0] err_cnt,
   output logic [EDW-1:0]          max_ed,
   output logic                    sat
);

   localparam int unsigned SW = ((ACC_W > EDW) ? ACC_W : EDW) + 1;
   localparam logic [SW-1:0] ACC_MAX = {{(SW-ACC_W){1'b0}}, {ACC_W{1'b1}}};

   mon_state_e              state_q, state_d;
   logic [SAMPLE_CNT_W-1:0] ns_q;
   logic [SAMPLE_CNT_W-1:0] acc_cnt;
   logic                    xfer;
   logic                    last_xfer;
   logic                    accept_start;
   logic                    s1_valid;
   logic                    ed_valid;
   logic [EDW-1:0]          ed;
   logic [SW-1:0]           sum_ext;

   err_dist_calc u_edc (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (xfer),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_r     (in_r),
      .s1_valid (s1_valid),
      .ed_valid (ed_valid),
      .ed       (ed)
   );

   assign xfer         = in_valid && in_ready;
   assign last_xfer    = xfer && (acc_cnt == (ns_q - SAMPLE_CNT_W'(1)));
   assign accept_start = (state_q == ST_IDLE) && start;
   assign sum_ext      = SW'(sum_ed) + SW'(ed);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // DRAIN exits once stage 1 is empty: the stage-2 entry retires into the
   // statistics on the same edge that enters DONE.
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_d = (num_samples == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            in_ready = (acc_cnt < ns_q);
            if (last_xfer) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!s1_valid) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ns_q    <= '0;
         acc_cnt <= '0;
         sum_ed  <= '0;
         err_cnt <= '0;
         sat     <= 1'b0;
      end else if (accept_start) begin
         ns_q    <= num_samples;
         acc_cnt <= '0;
         sum_ed  <= '0;
         err_cnt <= '0;
         sat     <= 1'b0;
      end else begin
         if (xfer) begin
            acc_cnt <= acc_cnt + SAMPLE_CNT_W'(1);
         end
         if (ed_valid) begin
            if (sum_ext > ACC_MAX) begin
               sum_ed <= '1;
               sat    <= 1'b1;
            end else begin
               sum_ed <= sum_ext[ACC_W-1:0];
            end
            err_cnt <= err_cnt + SAMPLE_CNT_W'(ed != '0);
         end
      end
   end

`ifdef ERR_MAX_TRACK_EN
   always_ff @(posedge clk) begin
      if (!rst_n || accept_start) begin
         max_ed <= '0;
      end else if (ed_valid && (ed > max_ed)) begin
         max_ed <= ed;
      end
   end
`else
   assign max_ed = '0;
`endif

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Directed self-checking bench for approx_mult_err_monitor (default and ACC_W=9 instances).
module tb_approx_mult_err_monitor;

`ifdef ERR_MAX_TRACK_EN
   localparam bit MAXEN = 1'b1;
`else
   localparam bit MAXEN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] num_samples;
   logic        in_valid;
   logic [7:0]  in_a, in_b;
   logic [15:0] in_r;

   logic        in_ready, busy, done, sat;
   logic [31:0] sum_ed;
   logic [15:0] err_cnt, max_ed;

   logic        in_ready9, busy9, done9, sat9;
   logic [8:0]  sum_ed9;
   logic [15:0] err_cnt9, max_ed9;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   approx_mult_err_monitor #(.SAMPLE_CNT_W(16), .ACC_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_r(in_r),
      .busy(busy), .done(done), .sum_ed(sum_ed), .err_cnt(err_cnt),
      .max_ed(max_ed), .sat(sat)
   );

   approx_mult_err_monitor #(.SAMPLE_CNT_W(16), .ACC_W(9)) dut9 (
      .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(in_ready9), .in_a(in_a), .in_b(in_b), .in_r(in_r),
      .busy(busy9), .done(done9), .sum_ed(sum_ed9), .err_cnt(err_cnt9),
      .max_ed(max_ed9), .sat(sat9)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 0);
      chk({tag, "_busy"},     32'(busy), 0);
      chk({tag, "_done"},     32'(done), 0);
      chk({tag, "_sum"},      sum_ed, 0);
      chk({tag, "_err"},      32'(err_cnt), 0);
      chk({tag, "_max"},      32'(max_ed), 0);
      chk({tag, "_sat"},      32'(sat), 0);
      chk({tag, "_sum9"},     32'(sum_ed9), 0);
   endtask

   task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] r);
      in_valid = v;
      in_a     = a;
      in_b     = b;
      in_r     = r;
   endtask

   initial begin
      int xfers;
      int dones;
      bit seen_last;

      rst_n = 1'b0; start = 1'b0; num_samples = '0;
      drive(1'b0, 8'd0, 8'd0, 16'd0);
      tick(); tick();
      chk_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // Window of 1: exact product, zero error
      num_samples = 16'd1; start = 1'b1;
      tick();
      start = 1'b0;
      chk("w1_busy", 32'(busy), 1);
      chk("w1_ready", 32'(in_ready), 1);
      drive(1'b1, 8'd15, 8'd15, 16'd225);
      tick();
      drive(1'b0, 8'd0, 8'd0, 16'd0);
      chk("w1_ready_after", 32'(in_ready), 0);
      tick();
      chk("w1_done_early", 32'(done), 0);
      tick();
      chk("w1_done", 32'(done), 1);
      chk("w1_sum", sum_ed, 0);
      chk("w1_err", 32'(err_cnt), 0);
      chk("w1_max", 32'(max_ed), 0);
      tick();
      chk("w1_done_off", 32'(done), 0);
      chk("w1_busy_off", 32'(busy), 0);

      // Window of 2: overestimate then underestimate
      num_samples = 16'd2; start = 1'b1;
      tick();
      start = 1'b0;
      drive(1'b1, 8'd255, 8'd255, 16'd65535);
      tick();
      drive(1'b1, 8'd3, 8'd5, 16'd13);
      tick();
      drive(1'b0, 8'd0, 8'd0, 16'd0);
      chk("w2_ready_after", 32'(in_ready), 0);
      tick(); tick();
      chk("w2_done", 32'(done), 1);
      chk("w2_sum", sum_ed, 512);
      chk("w2_err", 32'(err_cnt), 2);
      chk("w2_max", 32'(max_ed), MAXEN ? 510 : 0);
      chk("w2_sat", 32'(sat), 0);
      tick();
      chk("w2_busy_off", 32'(busy), 0);
      chk("w2_sum_hold", sum_ed, 512);

      // Saturation: 3 x ED=200 into a 9-bit accumulator
      num_samples = 16'd3; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'd10, 8'd10, 16'd300);
         tick();
      end
      drive(1'b0, 8'd0, 8'd0, 16'd0);
      tick(); tick();
      chk("sat_done9", 32'(done9), 1);
      chk("sat_sum9", 32'(sum_ed9), 511);
      chk("sat_flag9", 32'(sat9), 1);
      chk("sat_err9", 32'(err_cnt9), 3);
      chk("sat_sum32", sum_ed, 600);
      chk("sat_flag32", 32'(sat), 0);
      tick();

      // Zero-length window
      num_samples = 16'd0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("z_ready", 32'(in_ready), 0);
      chk("z_done", 32'(done), 1);
      chk("z_sum", sum_ed, 0);
      chk("z_err", 32'(err_cnt), 0);
      chk("z_sat9", 32'(sat9), 0);
      chk("z_sum9", 32'(sum_ed9), 0);
      tick();
      chk("z_done_off", 32'(done), 0);
      chk("z_busy_off", 32'(busy), 0);

      // Window of 4, gapped valid, re-pulsed start mid-run
      num_samples = 16'd4; start = 1'b1;
      tick();
      start = 1'b0;
      xfers = 0; dones = 0; seen_last = 1'b0;
      for (int c = 0; c < 20; c++) begin
         drive((c % 2) == 0, 8'd2, 8'd3, 16'd7);
         start = (c == 3);
         num_samples = (c == 3) ? 16'd9 : 16'd4;
         if (in_valid && in_ready) xfers++;
         tick();
         if (done) dones++;
         if (xfers == 4 && !seen_last) begin
            seen_last = 1'b1;
            chk("g_ready_after4", 32'(in_ready), 0);
         end
      end
      start = 1'b0;
      drive(1'b0, 8'd0, 8'd0, 16'd0);
      chk("g_xfers", 32'(xfers), 4);
      chk("g_dones", 32'(dones), 1);
      chk("g_sum", sum_ed, 4);
      chk("g_err", 32'(err_cnt), 4);
      chk("g_busy_off", 32'(busy), 0);

      // Reset mid-window after 2 of 5 transfers
      num_samples = 16'd5; start = 1'b1;
      tick();
      start = 1'b0;
      drive(1'b1, 8'd2, 8'd3, 16'd7);
      tick(); tick();
      drive(1'b0, 8'd0, 8'd0, 16'd0);
      tick();
      chk("r_sum_pre", sum_ed, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_all_zero("r_mid");
      dones = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (done || busy) dones++;
      end
      chk("r_no_done", 32'(dones), 0);
      chk("r_sum_post", sum_ed, 0);
      chk("r_err_post", 32'(err_cnt), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
